// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame constants and baud helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Integer division on purpose: the small baud error is tolerated, no fractional accumulator.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-time counter producing a pulse on the last cycle of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cfg
    $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
  end

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with valid/ready byte input and registered TXD
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 27000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       TXD
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       txd_q;
  logic       busy_q;
  logic       idle_q;
  logic       bit_done;
  logic       accept;

  // Holding the counter clear while idle makes the start bit full length from the accept edge.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .bit_done(bit_done)
  );

  assign tx_ready = idle_q && !reset;
  assign accept   = tx_valid && tx_ready;
  assign busy     = busy_q;
  assign TXD      = txd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift  <= tx_data;
            state  <= START;
            txd_q  <= 1'b0;
            busy_q <= 1'b1;
            idle_q <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_idx <= '0;
            txd_q   <= shift[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
              state   <= STOP;
              bit_idx <= '0;
              txd_q   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              txd_q   <= shift[1];
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            idle_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx at 4 clocks per bit
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       TXD;

  uart_tx #(
    .CLK_FREQ(8),
    .BAUD    (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .TXD     (TXD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_sent = 0;
  int n_dec = 0;
  bit chk_en = 1'b0;

  logic     line_q[$];
  logic [7:0] exp_bytes[$];
  int       acc_cyc[$];
  logic     exp_txd, exp_busy, exp_rdy;
  logic     prev_txd = 1'b1;
  bit       mon_active = 1'b0;
  int       mon_t = 0;
  logic [7:0] mon_byte = 8'h00;
  vec_t     vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: each accepted byte becomes 40 expected line samples; busy while any remain.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_txd  = (line_q.size() != 0) ? line_q[0] : 1'b1;
      exp_busy = (line_q.size() != 0);
      exp_rdy  = (line_q.size() == 0) && !reset;
      check("txd", TXD, exp_txd);
      check("busy", busy, exp_busy);
      check("tx_ready", tx_ready, exp_rdy);

      if (reset) begin
        mon_active = 1'b0;
      end else if (mon_active) begin
        mon_t++;
        if (mon_t == 2) begin
          check("mon_start", TXD, 0);
        end else if (mon_t >= 6 && mon_t <= 34 && (mon_t - 6) % 4 == 0) begin
          mon_byte[(mon_t - 6) / 4] = TXD;
        end else if (mon_t == 38) begin
          check("mon_stop", TXD, 1);
          check("mon_pending", exp_bytes.size() != 0, 1);
          if (exp_bytes.size() != 0) check("mon_byte", mon_byte, exp_bytes.pop_front());
          n_dec++;
          mon_active = 1'b0;
        end
      end else if (prev_txd == 1'b1 && TXD == 1'b0) begin
        mon_active = 1'b1;
        mon_t = 0;
      end
      prev_txd = TXD;

      if (reset) begin
        line_q.delete();
        exp_bytes.delete();
      end else if (line_q.size() != 0) begin
        void'(line_q.pop_front());
      end else if (tx_valid) begin
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < 4; k++) begin
            line_q.push_back((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : tx_data[b-1]);
          end
        end
        exp_bytes.push_back(tx_data);
        acc_cyc.push_back(cyc + 1);
      end
    end
  end

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: tx_ready got 0 expected 1 within 200 cycles");
    end
    at_drive();
    n_sent++;
  endtask

  task automatic send_byte(input logic [7:0] d);
    at_drive();
    tx_data  = d;
    tx_valid = 1'b1;
    wait_accept();
    tx_valid = 1'b0;
  endtask

  task automatic check_frame(input logic [9:0] frame);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("frame_txd", TXD, frame[i/4]);
      check("frame_busy", busy, 1);
    end
    @(negedge clk);
    check("ready_after_frame", tx_ready, 1);
    check("busy_after_frame", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h81, 10'b1_10000001_0};
    vecs[4] = '{8'hC3, 10'b1_11000011_0};
    vecs[5] = '{8'h01, 10'b1_00000001_0};

    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", tx_ready, 0);
    check("rst_txd", TXD, 1);
    check("rst_busy", busy, 0);
    at_drive();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_txd", TXD, 1);
      check("idle_ready", tx_ready, 1);
      check("idle_busy", busy, 0);
    end

    foreach (vecs[i]) begin
      send_byte(vecs[i].data);
      check_frame(vecs[i].frame);
    end

    // Valid held high across two bytes: accepts must be exactly one frame plus one cycle apart.
    acc_cyc.delete();
    at_drive();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    wait_accept();
    tx_data = 8'hFF;
    wait_accept();
    tx_valid = 1'b0;
    check("held_count", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("held_gap", acc_cyc[1] - acc_cyc[0], 41);

    // Offers made mid-frame must neither corrupt 0x81 nor be taken early.
    acc_cyc.delete();
    send_byte(8'h81);
    repeat (8) at_drive();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    at_drive();
    tx_valid = 1'b0;
    tx_data  = 8'h77;
    repeat (4) at_drive();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    wait_accept();
    tx_valid = 1'b0;
    check("late_count", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("late_gap", acc_cyc[1] - acc_cyc[0], 41);

    // One-cycle reset during data bit 3 of 0x55 abandons the frame.
    send_byte(8'h55);
    repeat (17) @(posedge clk);
    #2;
    reset = 1'b1;
    at_drive();
    reset = 1'b0;
    @(negedge clk);
    check("abort_txd", TXD, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", tx_ready, 1);
    send_byte(8'h12);
    check_frame(10'b1_00010010_0);

    for (int n = 0; n < 256; n++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      for (int g = 0; g < gap; g++) begin
        at_drive();
        tx_data = 8'($urandom);
      end
      send_byte(8'($urandom));
    end

    repeat (60) @(negedge clk);
    check("decoded_count", n_dec, n_sent - 1);
    check("pending_bytes", exp_bytes.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter that serialises bytes from the SoC core onto the board's TXD pin.
- Sits beside the LED/CPU path in soc. Runs on the undivided board clock.
- Uses a valid/ready byte handshake on the core side and a single idle-high serial line on the pin side.
- It is the transmit end of the serial link whose receive side (RXD) is a separate block.

Parameters:
- CLK_FREQ, 27000000: input clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 234 at defaults): cycles per serial bit. Elaboration error if < 2.

Ports:
- clk  input  1: system clock; all logic on rising edge.
- reset  input  1: synchronous, active-high reset.
- tx_data  input  8: byte to send; sampled only on an accept cycle.
- tx_valid  input  1: core offers tx_data.
- tx_ready  output  1: block can accept a byte this cycle.
- busy  output  1: frame in progress (START, DATA or STOP).
- TXD  output  1: serial line, idle high.

Behaviour:
- Reset values (cycle after reset is sampled high): TXD=1, tx_ready=0 while reset is high, busy=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame. TXD returns to 1 on the next edge, and the partial byte is discarded.
- States:
  - IDLE: tx_ready=1, TXD=1. Accept = tx_valid && tx_ready. On accept, latch tx_data into the shift register and go to START.
  - START: TXD=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TXD=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7's final cycle go to STOP.
  - STOP: TXD=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - Start bit begins on the cycle after accept (latency 1).
  - Frame occupies exactly 10*CLKS_PER_BIT cycles.
  - tx_ready rises on the first IDLE cycle after STOP completes, so the minimum accept-to-accept spacing is 10*CLKS_PER_BIT+1 cycles.
  - Back-to-back valid is accepted on that first IDLE cycle; there is no extra gap.
- tx_ready=0 and busy=1 in START, DATA and STOP. tx_valid and tx_data are ignored there; no byte is lost or corrupted by changes on them.
- tx_valid held high with tx_ready low is legal. The core keeps tx_data stable until accept.
- TXD is driven directly from a register (glitch-free, no combinational path to the pin).
- Bit-time counter:
  - Width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and then wraps to 0.
  - Cleared on accept, so the start bit is always full length.
- Bit index is 3 bits and wraps 7->0 only on the DATA->STOP transition.
- Integer-division baud error (about 0.16% at defaults) is accepted. No fractional accumulator.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP};
  - DATA_BITS=8 and STOP_BITS=1;
  - a function computing CLKS_PER_BIT from CLK_FREQ and BAUD (shared with the future uart_rx).
- One sub-module, uart_baud_gen:
  - parameter CLKS_PER_BIT;
  - inputs clk, reset and a clear input;
  - outputs a one-cycle bit_done pulse.
- uart_baud_gen is reused by the receiver.

Test Plan (CLK_FREQ=8, BAUD=2, so CLKS_PER_BIT=4):
- Reset, then idle 20 cycles -> TXD=1, tx_ready=1, busy=0 throughout.
- Send 0xA5 (one-cycle valid) -> TXD = 0 | 1,0,1,0,0,1,0,1 | 1, each level exactly 4 cycles. busy=1 for 40 cycles; tx_ready high on cycle 41 after accept.
- tx_valid held high with bytes 0x00 then 0xFF -> accepts are exactly 41 cycles apart. Line shows 9 low bits (start + data), then stop, then start, then 8 high data bits and stop.
- Change tx_data to 0x3C and pulse tx_valid while sending 0x81 -> the line carries 0x81 intact. The second offer is accepted only when tx_ready next rises.
- Assert reset for 1 cycle during data bit 3 of 0x55 -> TXD=1, busy=0, tx_ready=1 the cycle after reset drops. A following 0x12 frame is complete and correct.
- UART monitor at 4 cycles/bit on 256 random bytes with random valid gaps -> all bytes decoded in order, and every stop bit is high.
